// File: rtl/aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_dec_round_ctrl
//   Iterative AES inverse cipher: one round per clock, round keys fetched from an
//   external key store by index. The datapath helpers (inv_shiftRows,
//   inv_subBytes, inv_mixColumns) are purely combinational.
//
//   Byte order: bits [127:120] hold state byte 0; bytes run column-major, so
//   byte i sits at row i%4, column i/4.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. in_ready only depends on rk_valid and the FSM
// state; out_valid only on the FSM state, so neither side waits on the other
// combinationally.
//
// Ports
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : ciphertext handshake, in_data sampled on accept only
//   in_data [127:0]     : ciphertext
//   rk_idx [3:0]        : index of the round key wanted this cycle
//   rk [127:0]          : round key for rk_idx (same cycle)
//   rk_valid            : key store has rk; low stalls the block
//   out_valid/out_ready : plaintext handshake
//   out_data [127:0]    : plaintext, held while out_valid & !out_ready
//   busy                : high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------

module inv_shiftRows (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // Row r rotates right by r columns: out[r][c] = in[r][(c - r) mod 4].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(r+4*c) -: 8] = din[127-8*(r+4*((c-r+4)%4)) -: 8];
        end
    end
endmodule

module inv_subBytes (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[127-8*i -: 8] = INV_SBOX[din[127-8*i -: 8]];
    end
endmodule

module inv_mixColumns (
    input  logic [127:0] din,
    output logic [127:0] dout
);
    // GF(2^8) multiply by x, reduction polynomial 0x11b.
    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul9(input logic [7:0] b);
        return xt(xt(xt(b))) ^ b;
    endfunction

    function automatic logic [7:0] mulb(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(b) ^ b;
    endfunction

    function automatic logic [7:0] muld(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ b;
    endfunction

    function automatic logic [7:0] mule(input logic [7:0] b);
        return xt(xt(xt(b))) ^ xt(xt(b)) ^ xt(b);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign a0 = din[127-32*c -: 8];
        assign a1 = din[119-32*c -: 8];
        assign a2 = din[111-32*c -: 8];
        assign a3 = din[103-32*c -: 8];
        assign dout[127-32*c -: 8] = mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3);
        assign dout[119-32*c -: 8] = mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3);
        assign dout[111-32*c -: 8] = muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3);
        assign dout[103-32*c -: 8] = mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3);
    end
endmodule

module aes_dec_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    input  logic         rk_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);
    localparam logic [3:0] NR_IDX = 4'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } fsm_t;

    fsm_t         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [3:0]   round_q, round_d;

    logic [127:0] isr_out;
    logic [127:0] isb_out;
    logic [127:0] ark_out;
    logic [127:0] imc_out;

    // Shared datapath: FINAL uses ark_out directly, ROUND adds InvMixColumns.
    inv_shiftRows  u_isr (.din(state_q), .dout(isr_out));
    inv_subBytes   u_isb (.din(isr_out), .dout(isb_out));
    assign ark_out = isb_out ^ rk;
    inv_mixColumns u_imc (.din(ark_out), .dout(imc_out));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // rk_idx is decoded from fsm_q/round_q only, so the key store never sees
    // a path from its own rk/rk_valid back to its address.
    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        rk_idx    = 4'd0;

        case (fsm_q)
            IDLE: begin
                busy     = 1'b0;
                rk_idx   = NR_IDX;
                // Accepting needs the last round key in the same cycle.
                in_ready = rk_valid;
                if (in_valid && rk_valid) begin
                    state_d = in_data ^ rk;
                    round_d = NR_IDX - 4'd1;
                    fsm_d   = ROUND;
                end
            end
            ROUND: begin
                rk_idx = round_q;
                if (rk_valid) begin
                    state_d = imc_out;
                    round_d = round_q - 4'd1;
                    if (round_q == 4'd1) begin
                        fsm_d = FINAL;
                    end
                end
            end
            FINAL: begin
                rk_idx = 4'd0;
                if (rk_valid) begin
                    state_d = ark_out;
                    fsm_d   = DONE;
                end
            end
            DONE: begin
                rk_idx    = 4'd0;
                out_valid = 1'b1;
                out_data  = state_q;
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_aes_dec_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_aes_dec_round_ctrl
//   Directed bench for aes_dec_round_ctrl (NR=10) using the FIPS-197 C.1
//   AES-128 vector. The key store is modelled as a table of the expanded key,
//   indexed by rk_idx. Drivers push the expected plaintext when a ciphertext is
//   accepted; a monitor compares against the queue head whenever out_valid is
//   high and pops on the handshake.
//   Timing: drivers act and sample at negedge+1, the monitor at negedge+3.
// -----------------------------------------------------------------------------

module tb_aes_dec_round_ctrl;
    localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   rk_idx;
    logic [127:0] rk;
    logic         rk_valid;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [127:0] exp_q[$];
    logic [127:0] key_sched [16];

    aes_dec_round_ctrl #(.NR(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .rk_idx    (rk_idx),
        .rk        (rk),
        .rk_valid  (rk_valid),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    // ---------------- clock / reset block ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Key store: expanded FIPS-197 C.1 key, served the same cycle.
    assign rk = key_sched[rk_idx];

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitor: every cycle out_valid is high the data must match the head.
    always begin
        @(negedge clk);
        #3;
        if (rst_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got out_data %h with no block outstanding (cycle %0d)",
                         out_data, cyc);
            end else begin
                check("out_data", out_data, exp_q[0]);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Offer a ciphertext until accepted; returns the edge number of the accept.
    task automatic send(input logic [127:0] ct, input logic [127:0] pt, output int acc);
        int t;
        t        = 0;
        acc      = -1;
        in_valid = 1'b1;
        in_data  = ct;
        #1;
        while (in_ready !== 1'b1 && t < 100) begin
            tick();
            #1;
            t++;
        end
        if (in_ready !== 1'b1) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end else begin
            exp_q.push_back(pt);
            tick();
            acc      = cyc;
            in_valid = 1'b0;
            in_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
            check("busy_after_accept", 128'(busy), 128'd1);
        end
    endtask

    task automatic wait_valid(input int budget, output int seen);
        seen = -1;
        for (int t = 0; t < budget; t++) begin
            if (out_valid === 1'b1) begin
                seen = cyc;
                break;
            end
            tick();
        end
        if (seen < 0) fail_now("out_valid_timeout");
    endtask

    task automatic wait_idx(input logic [3:0] idx, input int budget);
        for (int t = 0; t < budget; t++) begin
            if (rk_idx === idx) break;
            tick();
        end
        check("reach_rk_idx", 128'(rk_idx), 128'(idx));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 128'(out_valid), 128'd0);
        check({tag, "_busy"},      128'(busy),      128'd0);
        check({tag, "_out_data"},  out_data,        128'd0);
        check({tag, "_rk_idx"},    128'(rk_idx),    128'd10);
        check({tag, "_in_ready"},  128'(in_ready),  128'(rk_valid));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc2, seen, c0;
        logic saw;
        logic [3:0] exp_idx;

        key_sched[0]  = 128'h000102030405060708090a0b0c0d0e0f;
        key_sched[1]  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
        key_sched[2]  = 128'hb692cf0b643dbdf1be9bc5006830b3fe;
        key_sched[3]  = 128'hb6ff744ed2c2c9bf6c590cbf0469bf41;
        key_sched[4]  = 128'h47f7f7bc95353e03f96c32bcfd058dfd;
        key_sched[5]  = 128'h3caaa3e8a99f9deb50f3af57adf622aa;
        key_sched[6]  = 128'h5e390f7df7a69296a7553dc10aa31f6b;
        key_sched[7]  = 128'h14f9701ae35fe28c440adf4d4ea9c026;
        key_sched[8]  = 128'h47438735a41c65b9e016baf4aebf7ad2;
        key_sched[9]  = 128'h549932d1f08557681093ed9cbe2c974e;
        key_sched[10] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        for (int i = 11; i < 16; i++) key_sched[i] = '0;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        rk_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        tick();

        // Reset state; in_ready tracks rk_valid combinationally in IDLE.
        check_reset_outputs("reset");
        rk_valid = 1'b0;
        #1;
        check("reset_in_ready_rkv0", 128'(in_ready), 128'd0);
        rk_valid = 1'b1;
        rst_n    = 1'b1;
        tick();

        // C.1 vector, full-rate: rk_idx sequence, in_ready low, out_valid at 10.
        send(CT, PT, acc);
        for (int k = 0; k <= 11; k++) begin
            if (k <= 8)       exp_idx = 4'(9 - k);
            else if (k <= 10) exp_idx = 4'd0;
            else              exp_idx = 4'd10;
            check($sformatf("c1_rk_idx_k%0d", k), 128'(rk_idx), 128'(exp_idx));
            check($sformatf("c1_in_ready_k%0d", k), 128'(in_ready), (k == 11) ? 128'd1 : 128'd0);
            check($sformatf("c1_out_valid_k%0d", k), 128'(out_valid), (k == 10) ? 128'd1 : 128'd0);
            if (k < 11) tick();
        end

        // Stall three cycles on the round using key 5.
        send(CT, PT, acc);
        wait_idx(4'd5, 20);
        rk_valid = 1'b0;
        repeat (3) begin
            tick();
            check("stall_rk_idx", 128'(rk_idx), 128'd5);
            check("stall_out_valid", 128'(out_valid), 128'd0);
        end
        rk_valid = 1'b1;
        wait_valid(40, seen);
        check("stall_latency", 128'(seen - acc), 128'd13);
        tick();

        // Consumer back-pressure for 20 cycles.
        out_ready = 1'b0;
        send(CT, PT, acc);
        wait_valid(40, seen);
        check("hold_latency", 128'(seen - acc), 128'd10);
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_out_valid", 128'(out_valid), 128'd1);
            check("hold_in_ready", 128'(in_ready), 128'd0);
        end
        out_ready = 1'b1;
        tick();
        check("hold_release_busy", 128'(busy), 128'd0);
        check("hold_release_in_ready", 128'(in_ready), 128'd1);

        // Reset in the middle of a block (rk_idx = 6).
        send(CT, PT, acc);
        wait_idx(4'd6, 20);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        exp_q.delete();
        rst_n = 1'b0;
        rst_n = 1'b1;
        saw   = 1'b0;
        repeat (15) begin
            tick();
            if (out_valid !== 1'b0) saw = 1'b1;
        end
        check("midreset_no_out_valid", 128'(saw), 128'd0);
        send(CT, PT, acc);
        wait_valid(40, seen);
        check("post_reset_latency", 128'(seen - acc), 128'd10);
        tick();

        // Back-to-back with in_valid held: second accept 12 edges after first.
        send(CT, PT, acc);
        send(CT, PT, acc2);
        check("b2b_interval", 128'(acc2 - acc), 128'd12);
        wait_valid(40, seen);
        check("b2b_second_latency", 128'(seen - acc2), 128'd10);
        tick();

        // IDLE with key store not ready: no accept until rk_valid rises.
        rk_valid = 1'b0;
        in_valid = 1'b1;
        in_data  = CT;
        repeat (3) begin
            tick();
            check("rkv0_in_ready", 128'(in_ready), 128'd0);
            check("rkv0_busy", 128'(busy), 128'd0);
        end
        rk_valid = 1'b1;
        c0 = cyc;
        send(CT, PT, acc);
        check("rkv0_accept_edge", 128'(acc - c0), 128'd1);
        wait_valid(40, seen);
        check("rkv0_latency", 128'(seen - acc), 128'd10);

        repeat (3) tick();
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
